// File: rtl/dbg_mem_seq.sv
// Debug-side sequencer for the system RAM debug port: single/burst byte reads and writes.
// Define DBG_MEM_BURST_EN to honour cmd_len; otherwise every command moves exactly one byte.
module dbg_mem_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        range_err,
  output logic        dbg_mem_op,
  output logic        dbg_mem_clk,
  output logic [15:0] dbg_addr,
  output logic [7:0]  dbg_data_in,
  output logic        dbg_RW,
  input  logic [7:0]  dbg_data_out
);

  typedef enum logic [2:0] {IDLE, WAIT_WD, SETUP, PULSE, LATCH, RD_HOLD} state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        mem_op_q, mem_op_d;
  logic        mem_clk_q, mem_clk_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        range_err_q, range_err_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        rw_q, rw_d;
  logic        last;
  logic        advance;

`ifdef DBG_MEM_BURST_EN
  logic [7:0] count_q, count_d;
  assign last = (count_q == '0);
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign last = 1'b1;
`endif

  // Output flops are loaded from the next state so every port is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_op_q    <= 1'b0;
      mem_clk_q   <= 1'b0;
      rd_data_q   <= '0;
      range_err_q <= 1'b0;
      addr_q      <= '0;
      data_in_q   <= '0;
      rw_q        <= 1'b1;
`ifdef DBG_MEM_BURST_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      mem_op_q    <= mem_op_d;
      mem_clk_q   <= mem_clk_d;
      rd_data_q   <= rd_data_d;
      range_err_q <= range_err_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      rw_q        <= rw_d;
`ifdef DBG_MEM_BURST_EN
      count_q     <= count_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WAIT_WD : SETUP;
      WAIT_WD: if (wr_valid) state_d = SETUP;
      SETUP:   state_d = PULSE;
      PULSE:   state_d = rw_q ? LATCH : (last ? IDLE : WAIT_WD);
      LATCH:   state_d = RD_HOLD;
      RD_HOLD: if (rd_ready) state_d = last ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end

  assign advance = !last && (((state_q == PULSE) && !rw_q) ||
                             ((state_q == RD_HOLD) && rd_ready));

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WAIT_WD);
    rd_valid_d  = (state_d == RD_HOLD);
    busy_d      = (state_d != IDLE);
    mem_op_d    = (state_d == SETUP) || (state_d == PULSE) || (state_d == LATCH);
    mem_clk_d   = (state_d == PULSE);
    rd_data_d   = rd_data_q;
    range_err_d = range_err_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    rw_d        = rw_q;
`ifdef DBG_MEM_BURST_EN
    count_d     = count_q;
`endif
    if ((state_q == IDLE) && cmd_valid) begin
      addr_d      = cmd_addr;
      rw_d        = ~cmd_write;
      range_err_d = 1'b0;
`ifdef DBG_MEM_BURST_EN
      count_d     = cmd_len;
`endif
    end
    if ((state_q == WAIT_WD) && wr_valid) data_in_d = wr_data;
    if ((state_q == SETUP) && addr_q[15]) range_err_d = 1'b1;
    // Upper half of the address space deselects the RAM, so its bus floats.
    if (state_q == LATCH) rd_data_d = addr_q[15] ? 8'hFF : dbg_data_out;
    if (advance) begin
      addr_d  = addr_q + 16'd1;
`ifdef DBG_MEM_BURST_EN
      count_d = count_q - 8'd1;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_mem_clk = mem_clk_q;
  assign rd_data     = rd_data_q;
  assign range_err   = range_err_q;
  assign dbg_addr    = addr_q;
  assign dbg_data_in = data_in_q;
  assign dbg_RW      = rw_q;

endmodule
